branch_recovery_ctrl: RTL and testbench

Sequences misprediction recovery for the rename stage's checkpoint stack. Mirrors the rename checkpoint stack by recording the ROB tag of every checkpointed branch. On a mispredict it issues the exact number of single-cycle recover pulses needed to unwind to that branch's checkpoint, then emits one fetch redirect. Sits between branch resolution, rename and fetch; also stalls decode while recovering or when the checkpoint stack is full.

---
 rtl/branch_recovery_ctrl_if.sv | 39 +++
 rtl/branch_recovery_ctrl.sv | 127 ++++++++++++
 tb/tb_branch_recovery_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_recovery_ctrl_if.sv
// Bundles rename-push, branch-resolve, flush and recovery outputs of branch_recovery_ctrl.
// slave = controller side, master = the environment that drives it.
interface branch_recovery_ctrl_if #(
  parameter int N_CHECKPTS = 8,
  parameter int ROB_TAG_W  = 6,
  parameter int XLEN       = 32
);
  localparam int DW = $clog2(N_CHECKPTS) + 1;

  logic                 ren_accept_i;
  logic                 ren_is_branch_i;
  logic [ROB_TAG_W-1:0] ren_rob_tag_i;
  logic                 br_valid_i;
  logic                 br_ready_o;
  logic [ROB_TAG_W-1:0] br_tag_i;
  logic                 br_mispredict_i;
  logic [XLEN-1:0]      br_target_i;
  logic                 flush_i;
  logic                 recover_o;
  logic                 redirect_valid_o;
  logic [XLEN-1:0]      redirect_pc_o;
  logic                 full_flush_o;
  logic                 stall_o;
  logic [DW-1:0]        depth_o;

  modport slave (
    input  ren_accept_i, ren_is_branch_i, ren_rob_tag_i,
    input  br_valid_i, br_tag_i, br_mispredict_i, br_target_i, flush_i,
    output br_ready_o, recover_o, redirect_valid_o, redirect_pc_o,
    output full_flush_o, stall_o, depth_o
  );

  modport master (
    output ren_accept_i, ren_is_branch_i, ren_rob_tag_i,
    output br_valid_i, br_tag_i, br_mispredict_i, br_target_i, flush_i,
    input  br_ready_o, recover_o, redirect_valid_o, redirect_pc_o,
    input  full_flush_o, stall_o, depth_o
  );
endinterface

// File: rtl/branch_recovery_ctrl.sv
// Mirrors rename's checkpoint stack by ROB tag; on mispredict emits one recover pulse per
// checkpoint to unwind (first pulse one cycle after resolve), then a single fetch redirect.
module branch_recovery_ctrl #(
  parameter int N_CHECKPTS = 8,
  parameter int ROB_TAG_W  = 6,
  parameter int XLEN       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  branch_recovery_ctrl_if.slave   bus
);
  localparam int DW = $clog2(N_CHECKPTS) + 1;

  typedef enum logic [1:0] {IDLE, RECOVER, REDIRECT} state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic [DW-1:0]        count_q, count_d;
  logic [ROB_TAG_W-1:0] tag_q [N_CHECKPTS];
  logic [ROB_TAG_W-1:0] tag_d [N_CHECKPTS];
  logic [XLEN-1:0]      target_q, target_d;
  logic [XLEN-1:0]      redirect_pc_q, redirect_pc_d;
  logic                 full_flush_q, full_flush_d;

  logic                 full;
  logic                 push;
  logic                 fire;
  logic                 hit;
  logic [DW-1:0]        hit_idx;
  logic [DW-1:0]        depth_next;

  assign full       = (depth_q == DW'(N_CHECKPTS));
  assign push       = bus.ren_accept_i & bus.ren_is_branch_i & ~full &
                      (state_q == IDLE) & ~bus.flush_i;
  assign fire       = bus.br_valid_i & (state_q == IDLE);
  assign depth_next = push ? depth_q + DW'(1) : depth_q;

  // Scan downward so the last assignment leaves the oldest (lowest) matching entry.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_CHECKPTS - 1; i >= 0; i--) begin
      if ((DW'(i) < depth_q) && (tag_q[i] == bus.br_tag_i)) begin
        hit     = 1'b1;
        hit_idx = DW'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    depth_d       = depth_q;
    count_d       = count_q;
    target_d      = target_q;
    redirect_pc_d = redirect_pc_q;
    full_flush_d  = 1'b0;
    for (int i = 0; i < N_CHECKPTS; i++) begin
      tag_d[i] = tag_q[i];
      if (push && (DW'(i) == depth_q)) tag_d[i] = bus.ren_rob_tag_i;
    end

    case (state_q)
      IDLE: begin
        depth_d = depth_next;
        if (fire && bus.br_mispredict_i) begin
          target_d = bus.br_target_i;
          if (hit) begin
            // A same-cycle push sits above the hit entry and must be unwound too.
            count_d = depth_next - hit_idx;
            state_d = RECOVER;
          end else begin
            depth_d       = '0;
            full_flush_d  = 1'b1;
            redirect_pc_d = bus.br_target_i;
            state_d       = REDIRECT;
          end
        end
      end
      RECOVER: begin
        depth_d = depth_q - DW'(1);
        count_d = count_q - DW'(1);
        if (count_q == DW'(1)) begin
          redirect_pc_d = target_q;
          state_d       = REDIRECT;
        end
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (bus.flush_i) begin
      state_d       = IDLE;
      depth_d       = '0;
      count_d       = '0;
      full_flush_d  = 1'b0;
      redirect_pc_d = redirect_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      depth_q       <= '0;
      count_q       <= '0;
      target_q      <= '0;
      redirect_pc_q <= '0;
      full_flush_q  <= 1'b0;
      for (int i = 0; i < N_CHECKPTS; i++) tag_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      depth_q       <= depth_d;
      count_q       <= count_d;
      target_q      <= target_d;
      redirect_pc_q <= redirect_pc_d;
      full_flush_q  <= full_flush_d;
      for (int i = 0; i < N_CHECKPTS; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign bus.br_ready_o       = (state_q == IDLE);
  assign bus.recover_o        = (state_q == RECOVER);
  assign bus.redirect_valid_o = (state_q == REDIRECT);
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign bus.full_flush_o     = full_flush_q;
  assign bus.stall_o          = (state_q != IDLE) | full;
  assign bus.depth_o          = depth_q;
endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed bench for branch_recovery_ctrl: push/mispredict/flush/reset scenarios with
// hand-computed expectations checked one cycle step at a time.
module tb_branch_recovery_ctrl;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  branch_recovery_ctrl_if #(.N_CHECKPTS(8), .ROB_TAG_W(6), .XLEN(32)) bus ();

  branch_recovery_ctrl #(.N_CHECKPTS(8), .ROB_TAG_W(6), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] tag);
    bus.ren_accept_i    = 1'b1;
    bus.ren_is_branch_i = 1'b1;
    bus.ren_rob_tag_i   = tag;
    tick();
    bus.ren_accept_i    = 1'b0;
    bus.ren_is_branch_i = 1'b0;
  endtask

  task automatic resolve_drive(input logic [5:0] tag, input logic mis, input logic [31:0] tgt);
    bus.br_valid_i      = 1'b1;
    bus.br_tag_i        = tag;
    bus.br_mispredict_i = mis;
    bus.br_target_i     = tgt;
  endtask

  task automatic resolve_clear();
    bus.br_valid_i      = 1'b0;
    bus.br_mispredict_i = 1'b0;
  endtask

  initial begin
    rst                 = 1'b1;
    bus.ren_accept_i    = 1'b0;
    bus.ren_is_branch_i = 1'b0;
    bus.ren_rob_tag_i   = '0;
    bus.br_valid_i      = 1'b0;
    bus.br_tag_i        = '0;
    bus.br_mispredict_i = 1'b0;
    bus.br_target_i     = '0;
    bus.flush_i         = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ready",    bus.br_ready_o,       1);
    chk("rst_depth",    bus.depth_o,          0);
    chk("rst_stall",    bus.stall_o,          0);
    chk("rst_recover",  bus.recover_o,        0);
    chk("rst_redirect", bus.redirect_valid_o, 0);
    chk("rst_fflush",   bus.full_flush_o,     0);
    chk("rst_pc",       bus.redirect_pc_o,    0);

    // Scenario 1: tags 3,7,12; mispredict 7 -> 2 pulses
    push(6'd3); push(6'd7); push(6'd12);
    chk("s1_depth3", bus.depth_o, 3);
    resolve_drive(6'd7, 1'b1, 32'h100);
    tick();
    resolve_clear();
    chk("s1_rec1",    bus.recover_o,  1);
    chk("s1_depth_a", bus.depth_o,    3);
    chk("s1_stall_a", bus.stall_o,    1);
    chk("s1_ready_a", bus.br_ready_o, 0);
    tick();
    chk("s1_rec2",    bus.recover_o,  1);
    chk("s1_depth_b", bus.depth_o,    2);
    tick();
    chk("s1_rec_off", bus.recover_o,        0);
    chk("s1_redir",   bus.redirect_valid_o, 1);
    chk("s1_pc",      bus.redirect_pc_o,    32'h100);
    chk("s1_depth_c", bus.depth_o,          1);
    chk("s1_stall_c", bus.stall_o,          1);
    chk("s1_fflush",  bus.full_flush_o,     0);
    tick();
    chk("s1_redir_off", bus.redirect_valid_o, 0);
    chk("s1_ready_end", bus.br_ready_o,       1);
    chk("s1_stall_end", bus.stall_o,          0);
    chk("s1_pc_hold",   bus.redirect_pc_o,    32'h100);

    // Flush to empty
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("fl_depth", bus.depth_o, 0);

    // Scenario 2: tags 4,9; mispredict 4 with same-cycle push of 10 -> 3 pulses
    push(6'd4); push(6'd9);
    bus.ren_accept_i    = 1'b1;
    bus.ren_is_branch_i = 1'b1;
    bus.ren_rob_tag_i   = 6'd10;
    resolve_drive(6'd4, 1'b1, 32'h200);
    tick();
    bus.ren_accept_i    = 1'b0;
    bus.ren_is_branch_i = 1'b0;
    resolve_clear();
    chk("s2_rec1", bus.recover_o, 1);
    chk("s2_d3",   bus.depth_o,   3);
    tick();
    chk("s2_rec2", bus.recover_o, 1);
    chk("s2_d2",   bus.depth_o,   2);
    tick();
    chk("s2_rec3", bus.recover_o, 1);
    chk("s2_d1",   bus.depth_o,   1);
    tick();
    chk("s2_redir", bus.redirect_valid_o, 1);
    chk("s2_rec_off", bus.recover_o,      0);
    chk("s2_d0",    bus.depth_o,          0);
    chk("s2_pc",    bus.redirect_pc_o,    32'h200);
    tick();

    // Scenario 3: unknown tag 20 at depth 2 -> full flush + redirect, no recover
    push(6'd1); push(6'd2);
    resolve_drive(6'd20, 1'b1, 32'h300);
    tick();
    resolve_clear();
    chk("s3_fflush", bus.full_flush_o,     1);
    chk("s3_redir",  bus.redirect_valid_o, 1);
    chk("s3_norec",  bus.recover_o,        0);
    chk("s3_depth",  bus.depth_o,          0);
    chk("s3_pc",     bus.redirect_pc_o,    32'h300);
    tick();
    chk("s3_fflush_off", bus.full_flush_o,     0);
    chk("s3_redir_off",  bus.redirect_valid_o, 0);
    chk("s3_ready",      bus.br_ready_o,       1);

    // Scenario 4: fill 8, drop 9th push, correct-predict resolve
    for (int i = 0; i < 8; i++) push(6'(i));
    chk("s4_depth8", bus.depth_o, 8);
    chk("s4_stall",  bus.stall_o, 1);
    push(6'd9);
    chk("s4_drop", bus.depth_o, 8);
    resolve_drive(6'd5, 1'b0, 32'h999);
    tick();
    resolve_clear();
    chk("s4_ready",   bus.br_ready_o,       1);
    chk("s4_norec",   bus.recover_o,        0);
    chk("s4_noredir", bus.redirect_valid_o, 0);
    chk("s4_depth",   bus.depth_o,          8);
    chk("s4_pc",      bus.redirect_pc_o,    32'h300);
    // Youngest entry: single pulse
    resolve_drive(6'd7, 1'b1, 32'h380);
    tick();
    resolve_clear();
    chk("s4_rec1",  bus.recover_o, 1);
    tick();
    chk("s4_redir", bus.redirect_valid_o, 1);
    chk("s4_d7",    bus.depth_o,          7);
    tick();

    // Scenario 5: tag 2 at depth 7 -> 5 pulses; held request, then flush mid-recovery
    resolve_drive(6'd2, 1'b1, 32'h400);
    tick();
    resolve_drive(6'd0, 1'b1, 32'h444);
    chk("s5_rec",     bus.recover_o,  1);
    chk("s5_noready", bus.br_ready_o, 0);
    tick();
    chk("s5_rec2",    bus.recover_o,  1);
    chk("s5_d6",      bus.depth_o,    6);
    resolve_clear();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("s5_idle",    bus.br_ready_o,       1);
    chk("s5_depth",   bus.depth_o,          0);
    chk("s5_norec",   bus.recover_o,        0);
    chk("s5_noredir", bus.redirect_valid_o, 0);
    chk("s5_stall",   bus.stall_o,          0);
    tick();
    chk("s5_noredir2", bus.redirect_valid_o, 0);

    // Scenario 6: reset while in REDIRECT
    push(6'd5);
    resolve_drive(6'd5, 1'b1, 32'h500);
    tick();
    resolve_clear();
    chk("s6_rec", bus.recover_o, 1);
    tick();
    chk("s6_redir", bus.redirect_valid_o, 1);
    chk("s6_pc",    bus.redirect_pc_o,    32'h500);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_redir_off", bus.redirect_valid_o, 0);
    chk("s6_ready",     bus.br_ready_o,       1);
    chk("s6_pc0",       bus.redirect_pc_o,    0);
    chk("s6_depth",     bus.depth_o,          0);
    chk("s6_stall",     bus.stall_o,          0);
    chk("s6_fflush",    bus.full_flush_o,     0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
